// File: rtl/mux4_scan.sv
// Scans a downstream 4:1 mux by stepping its select, waiting SETTLE cycles per input and sampling Y.
// Define MUX4_SCAN_CONT_EN to rescan continuously after a single start (only rst stops it).
module mux4_scan #(
    parameter int unsigned SETTLE = 1  // legal range 1..15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       Y,
    output logic [1:0] S,
    output logic       E,
    output logic [3:0] D,
    output logic       valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [1:0] sel_q,   sel_d;
    logic       en_n_q,  en_n_d;
    logic [3:0] data_q,  data_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] cnt_q,   cnt_d;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        sel_d    = sel_q;
        en_n_d   = en_n_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETTLE;
                    sel_d   = 2'd0;
                    en_n_d  = 1'b0;
                    cnt_d   = SETTLE_LD;
                end
            end

            ST_SETTLE: begin
                cnt_d = 4'(cnt_q - 4'd1);
                if (cnt_q <= 4'd1) begin
                    state_d = ST_SAMPLE;
                end
            end

            ST_SAMPLE: begin
                shadow_d[sel_q] = Y;
                if (sel_q == 2'd3) begin
                    // D must already include the bit captured on this same edge.
                    state_d = ST_DONE;
                    en_n_d  = 1'b1;
                    data_d  = shadow_d;
                end else begin
                    state_d = ST_SETTLE;
                    sel_d   = 2'(sel_q + 2'd1);
                    cnt_d   = SETTLE_LD;
                end
            end

            ST_DONE: begin
`ifdef MUX4_SCAN_CONT_EN
                state_d = ST_SETTLE;
                sel_d   = 2'd0;
                en_n_d  = 1'b0;
                cnt_d   = SETTLE_LD;
`else
                state_d = ST_IDLE;
                sel_d   = 2'd0;
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            sel_q    <= 2'd0;
            en_n_q   <= 1'b1;
            data_q   <= 4'd0;
            shadow_q <= 4'd0;
            cnt_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            en_n_q   <= en_n_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign S     = sel_q;
    assign E     = en_n_q;
    assign D     = data_q;
    assign valid = (state_q == ST_DONE);
    assign busy  = (state_q != ST_IDLE);

    a_enable_tracks_state: assert property (@(posedge clk) disable iff (rst)
        E == !(state_q == ST_SETTLE || state_q == ST_SAMPLE));

    a_valid_single_cycle: assert property (@(posedge clk) disable iff (rst)
        valid |=> !valid);

    a_settle_count_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_SETTLE) |-> (cnt_q >= 4'd1 && cnt_q <= SETTLE_LD));

    a_done_at_last_select: assert property (@(posedge clk) disable iff (rst)
        (state_q == ST_DONE) |-> (sel_q == 2'd3));

endmodule

// File: tb/tb_mux4_scan.sv
// Self-checking bench for mux4_scan: two instances (SETTLE=1 and SETTLE=3) against a scan-position model.
// Build with MUX4_SCAN_CONT_EN to exercise the continuous-scan variant.
module tb_mux4_scan;

`ifdef MUX4_SCAN_CONT_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] mux_i = 4'd0;

    logic [1:0] s0, s1;
    logic       e0, e1, v0, v1, b0, b1;
    logic [3:0] d0, d1;
    logic       y0, y1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    // Bench-side 4:1 mux with active-low enable.
    assign y0 = e0 ? 1'b0 : mux_i[s0];
    assign y1 = e1 ? 1'b0 : mux_i[s1];

    mux4_scan #(.SETTLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .Y(y0),
        .S(s0), .E(e0), .D(d0), .valid(v0), .busy(b0)
    );

    mux4_scan #(.SETTLE(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .Y(y1),
        .S(s1), .E(e1), .D(d1), .valid(v1), .busy(b1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference model: a scan is a sequence of 4*(n+1) enabled cycles followed by one DONE cycle.
    int         nset[2] = '{1, 3};
    bit         act[2]  = '{1'b0, 1'b0};
    int         pos[2]  = '{0, 0};
    logic [3:0] cur[2]  = '{4'd0, 4'd0};
    logic [3:0] exp_d[2] = '{4'd0, 4'd0};

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            int per;
            int len;
            per = nset[j] + 1;
            len = 4 * per;
            if (rst) begin
                act[j]   = 1'b0;
                pos[j]   = 0;
                exp_d[j] = 4'd0;
            end else if (!act[j]) begin
                if (start) begin
                    act[j] = 1'b1;
                    pos[j] = 0;
                end
            end else if (pos[j] < len) begin
                if (pos[j] % per == per - 1) cur[j][pos[j] / per] = mux_i[pos[j] / per];
                pos[j]++;
                if (pos[j] == len) exp_d[j] = cur[j];
            end else begin
                if (CONT) pos[j] = 0;
                else act[j] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic compare_one(input int j, input logic [1:0] s, input logic e, input logic [3:0] d,
                               input logic v, input logic b);
        int per;
        int len;
        logic [1:0] es;
        logic ee, ev, eb;
        per = nset[j] + 1;
        len = 4 * per;
        if (!act[j]) begin
            es = 2'd0; ee = 1'b1; ev = 1'b0; eb = 1'b0;
        end else if (pos[j] < len) begin
            es = 2'(pos[j] / per); ee = 1'b0; ev = 1'b0; eb = 1'b1;
        end else begin
            es = 2'd3; ee = 1'b1; ev = 1'b1; eb = 1'b1;
        end
        check($sformatf("u%0d_S", j), 32'(s), 32'(es));
        check($sformatf("u%0d_E", j), 32'(e), 32'(ee));
        check($sformatf("u%0d_D", j), 32'(d), 32'(exp_d[j]));
        check($sformatf("u%0d_valid", j), 32'(v), 32'(ev));
        check($sformatf("u%0d_busy", j), 32'(b), 32'(eb));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            compare_one(0, s0, e0, d0, v0, b0);
            compare_one(1, s1, e1, d1, v1, b1);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Waits for valid on the chosen instance; returns the cycle it was seen, or -1 on timeout.
    task automatic wait_valid(input int j, input int budget, output int at);
        at = -1;
        for (int k = 0; k < budget; k++) begin
            if ((j == 0 && v0) || (j == 1 && v1)) begin
                at = cyc;
                break;
            end
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int c0;
        int got;
        int n_e_low;
        int vq[$];

        rst = 1'b1;
        idle_cycles(3);
        chk_en = 1'b1;
        rst = 1'b0;
        check("reset_S", 32'(s0), 32'd0);
        check("reset_E", 32'(e0), 32'd1);
        check("reset_D", 32'(d0), 32'd0);
        check("reset_busy", 32'(b0), 32'd0);
        idle_cycles(2);

`ifndef MUX4_SCAN_CONT_EN
        // Single scan, SETTLE=1, I=1001: valid at start+9 and E low for 8 cycles.
        mux_i = 4'b1001;
        start = 1'b1;
        c0 = cyc;
        step();
        start = 1'b0;
        n_e_low = 0;
        got = -1;
        for (int k = 0; k < 30; k++) begin
            if (!e0) n_e_low++;
            if (v0) begin
                got = cyc;
                break;
            end
            step();
        end
        check("s1_valid_cycle", 32'(got), 32'(c0 + 9));
        check("s1_D", 32'(d0), 32'h9);
        check("s1_E_low_cycles", 32'(n_e_low), 32'd8);
        step();
        check("s1_valid_pulse", 32'(v0), 32'd0);
        check("s1_busy_falls", 32'(b0), 32'd0);
        idle_cycles(20);

        // SETTLE=3, I=0110: valid at start+17.
        mux_i = 4'b0110;
        start = 1'b1;
        c0 = cyc;
        step();
        start = 1'b0;
        wait_valid(1, 40, got);
        check("s3_valid_cycle", 32'(got), 32'(c0 + 17));
        check("s3_D", 32'(d1), 32'h6);
        idle_cycles(10);

        // Reset in cycle 5 of a scan: scan aborts, D cleared, no valid.
        mux_i = 4'b1111;
        start = 1'b1;
        step();
        start = 1'b0;
        idle_cycles(4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_S", 32'(s0), 32'd0);
        check("abort_E", 32'(e0), 32'd1);
        check("abort_D", 32'(d0), 32'd0);
        check("abort_busy", 32'(b0), 32'd0);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            if (v0 || v1) got++;
            step();
        end
        check("abort_no_valid", 32'(got), 32'd0);
        check("abort_D_held", 32'(d0), 32'd0);

        // start held for 20 cycles: back-to-back scans, valids at +9 and +19.
        mux_i = 4'b0101;
        c0 = cyc;
        for (int k = 0; k < 26; k++) begin
            start = (k < 20);
            if (v0) vq.push_back(cyc);
            step();
        end
        start = 1'b0;
        check("held_valid_count", 32'(vq.size()), 32'd2);
        if (vq.size() >= 2) begin
            check("held_valid_first", 32'(vq[0]), 32'(c0 + 9));
            check("held_valid_second", 32'(vq[1]), 32'(c0 + 19));
        end
        idle_cycles(30);
`else
        // Continuous scan: one start, then valid recurs every DONE cycle plus 4*(SETTLE+1).
        mux_i = 4'b1001;
        start = 1'b1;
        c0 = cyc;
        step();
        start = 1'b0;
        wait_valid(0, 30, got);
        check("cont_first_valid", 32'(got), 32'(c0 + 9));
        check("cont_first_D", 32'(d0), 32'h9);
        c0 = got;
        step();
        mux_i = 4'b1111;
        check("cont_busy_between", 32'(b0), 32'd1);
        wait_valid(0, 30, got);
        check("cont_period", 32'(got - c0), 32'd9);
        check("cont_second_D", 32'(d0), 32'hF);
        idle_cycles(5);
`endif

        // Randomized traffic: start, mux inputs and occasional reset.
        for (int k = 0; k < 3000; k++) begin
            start = ($urandom_range(0, 3) == 0);
            mux_i = 4'($urandom);
            rst   = ($urandom_range(0, 99) == 0);
            step();
        end
        start = 1'b0;
        rst = 1'b0;
        idle_cycles(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
